axi_lite_reg_slave: RTL
=======================

# axi_lite_reg_slave

AXI4-Lite responder: a bank of `NUM_REGS` read/write control registers behind one AXI4-Lite slave port. It terminates the `axi_lite_if.SLAVE` side of the interconnect, typically downstream of the 2-master arbiter. It exposes register contents and per-register write strobes to fabric logic.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: AXI data width; must be 32 or 64.
- `NUM_REGS`, 8: number of registers; power of two, at least 2.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_if`  interface  `axi_lite_if.SLAVE`  AXI4-Lite channels AW/W/B/AR/R.
  - Inputs: AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY.
  - Outputs: AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID.
- `reg_q`  out  NUM_REGS*DATA_WIDTH  register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `wr_pulse`  out  NUM_REGS  one-cycle strobe per register after a committed write.

## Operation
- Byte offset bits: OB = log2(DATA_WIDTH/8). Index = ADDR[OB+log2(NUM_REGS)-1 : OB].
- An address is out of range if any bit above the index field is 1. ADDR[OB-1:0] is ignored.
- Write path: two hold flags, `aw_held` and `w_held`, plus a `b_pend` (BVALID) register.
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - The AW and W handshakes are independent; either may arrive first, or both in the same cycle. The address and data/strobe are captured into holding registers.
  - Commit occurs on the edge where AW (held or handshaking) and W (held or handshaking) are both available.
  - On commit, each byte k of the register with WSTRB[k]=1 is updated. Both hold flags clear. BVALID is set to 1.
  - BVALID stays high until the edge where BREADY=1. BRESP is stable while BVALID is high.
  - wr_pulse[idx] = 1 for exactly the cycle after commit, for in-range writes only.
  - WSTRB=0 still commits, gives an OKAY response and pulses wr_pulse, but changes no data.
- Read path: states R_IDLE and R_VALID.
  - ARREADY = (state == R_IDLE).
  - On the AR handshake: RDATA captures reg[idx], RRESP is set, and the state moves to R_VALID.
  - In R_VALID, RDATA/RRESP/RVALID are held until RREADY=1, then the state returns to R_IDLE.
- Same-edge read and write to the same register: the read returns the pre-write value.
- Write and read paths are fully concurrent.
- Response codes: OKAY = 2'b00, SLVERR = 2'b10; see Configuration.

## Timing
- Reset values:
  - All registers 0; reg_q = 0; wr_pulse = 0.
  - BVALID = 0; BRESP = 2'b00.
  - RVALID = 0; RDATA = 0; RRESP = 2'b00.
  - Hold flags 0; read state R_IDLE.
  - AWREADY, WREADY and ARREADY read 1 during and after reset.
- Write latency: commit edge N gives BVALID = 1 and the new reg_q in cycle N+1. Throughput is at most one write per 2 cycles (READYs are low while BVALID is high).
- Read latency: AR handshake at edge N gives RVALID = 1 in cycle N+1. Throughput is at most one read per 2 cycles.
- A BREADY or RREADY that is already high yields a single-cycle valid.
- VALID must never depend on READY. All outputs except the READYs are registered.
- Reset mid-transaction: held AW/W state, pending B and pending R are discarded immediately, registers clear, and no wr_pulse is generated.

## Configuration
- `AXIL_REG_SLVERR_EN` defined:
  - Out-of-range writes are dropped with BRESP = SLVERR and no wr_pulse.
  - Out-of-range reads return RDATA = 0, RRESP = SLVERR.
- Not defined:
  - Out-of-range writes are dropped with BRESP = OKAY.
  - Out-of-range reads return RDATA = 0, RRESP = OKAY.
  - The upper address bits are not decoded for error signalling.

## Test plan
- Write 0xDEADBEEF to address 0x04 with WSTRB 0xF, AW and W in the same cycle, BREADY=1 -> BVALID 1 cycle later with BRESP 00; reg_q[63:32] = 0xDEADBEEF; wr_pulse = 8'b0000_0010 for one cycle.
- W arrives 3 cycles before AW (addr 0x08, data 0x12345678, WSTRB 0x3) onto reg2 = 0xAAAAAAAA -> WREADY low after the W handshake; commit on the AW edge; reg2 = 0xAAAA5678.
- Read 0x04 with RREADY held low for 4 cycles -> RVALID is high from AR+1, and RDATA = 0xDEADBEEF stays stable until the RREADY edge; ARREADY is low throughout.
- Write 0x11111111 and read the same address 0x0C on the same edge (reg3 = 0) -> RDATA = 0; a following read returns 0x11111111.
- Address 0x40 with NUM_REGS=8: write then read -> with the macro, BRESP = RRESP = 2'b10 and RDATA = 0; without it, both 2'b00; all registers unchanged.
- Assert rst while BVALID and RVALID are pending -> both drop asynchronously; reg_q = 0; after release, a fresh write/read completes normally.

Source files
------------

// File: rtl/axi_lite_reg_slave_if.sv
// axi_lite_if: AXI4-Lite channel bundle (AW/W/B/AR/R) with SLAVE and MASTER views.
interface axi_lite_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;
   modport SLAVE (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport MASTER (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite bank of NUM_REGS control registers with per-register write strobes.
// Define AXIL_REG_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi_lite_reg_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   axi_lite_if.SLAVE                      s_if,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            wr_pulse
);
   localparam int OB = $clog2(DATA_WIDTH / 8);
   localparam int IW = $clog2(NUM_REGS);
   localparam int NB = DATA_WIDTH / 8;
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
`ifdef AXIL_REG_SLVERR_EN
   localparam logic SLVERR_EN = 1'b1;
`else
   localparam logic SLVERR_EN = 1'b0;
`endif

   typedef enum logic {R_IDLE, R_VALID} r_state_t;

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
   logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [NB-1:0]         wstrb_q, wstrb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
   r_state_t              r_state_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            rresp_q;

   logic                  aw_hs, w_hs, commit, wr_oor, rd_oor;
   logic [ADDR_WIDTH-1:0] wr_addr, wr_word, rd_word;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NB-1:0]         wr_strb;
   logic [IW-1:0]         wr_idx, rd_idx;

   assign s_if.awready = !aw_held_q && !bvalid_q;
   assign s_if.wready  = !w_held_q && !bvalid_q;
   assign s_if.bvalid  = bvalid_q;
   assign s_if.bresp   = bresp_q;
   assign s_if.arready = r_state_q == R_IDLE;
   assign s_if.rvalid  = r_state_q == R_VALID;
   assign s_if.rdata   = rdata_q;
   assign s_if.rresp   = rresp_q;
   assign reg_q        = regs_q;
   assign wr_pulse     = wr_pulse_q;

   always_comb begin
      aw_hs   = s_if.awvalid && s_if.awready;
      w_hs    = s_if.wvalid && s_if.wready;
      commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
      wr_addr = aw_held_q ? awaddr_q : s_if.awaddr;
      wr_data = w_held_q ? wdata_q : s_if.wdata;
      wr_strb = w_held_q ? wstrb_q : s_if.wstrb;
      wr_word = wr_addr >> OB;
      wr_idx  = wr_word[IW-1:0];
      wr_oor  = |(wr_word >> IW);
      rd_word = s_if.araddr >> OB;
      rd_idx  = rd_word[IW-1:0];
      rd_oor  = |(rd_word >> IW);
      aw_held_d  = commit ? 1'b0 : aw_held_q || aw_hs;
      w_held_d   = commit ? 1'b0 : w_held_q || w_hs;
      awaddr_d   = aw_hs ? s_if.awaddr : awaddr_q;
      wdata_d    = w_hs ? s_if.wdata : wdata_q;
      wstrb_d    = w_hs ? s_if.wstrb : wstrb_q;
      bvalid_d   = commit ? 1'b1 : bvalid_q && !s_if.bready;
      bresp_d    = commit ? ((wr_oor && SLVERR_EN) ? SLVERR : OKAY) : bresp_q;
      wr_pulse_d = (commit && !wr_oor) ? NUM_REGS'(1) << wr_idx : '0;
      regs_d     = regs_q;
      for (int k = 0; k < NB; k++)
         if (commit && !wr_oor && wr_strb[k]) regs_d[wr_idx][k*8 +: 8] = wr_data[k*8 +: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q     <= '0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= OKAY;
         wr_pulse_q <= '0;
      end else begin
         regs_q     <= regs_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

   // Reads sample regs_q, so a same-edge write is seen only by the next read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= OKAY;
      end else begin
         case (r_state_q)
            R_IDLE:
               if (s_if.arvalid) begin
                  rdata_q   <= rd_oor ? '0 : regs_q[rd_idx];
                  rresp_q   <= (rd_oor && SLVERR_EN) ? SLVERR : OKAY;
                  r_state_q <= R_VALID;
               end
            R_VALID:
               if (s_if.rready) r_state_q <= R_IDLE;
            default: r_state_q <= R_IDLE;
         endcase
      end
   end
endmodule
